// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage MIPS pipeline (between EX and WB).
// Registers the EX result, waits on the data-SRAM read return, keeps a hold
// buffer for read data that arrives while MEM is frozen, and formats load data
// (byte/half/word, sign or zero extended) for write-back and forwarding.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   flush              pipeline flush (clears the stage, beats stall)
//   stall[5:0]         stall vector; bit3 = MEM, bit4 = WB; 1 = stop
//   ex_to_mem_bus      {hilo 66, pc 32, ram_en, ram_wen 4, load_type 3,
//                       addr_lo 2, rf_we, rf_waddr 5, rf_wdata 32}
//   data_sram_rdata    read data from the data SRAM
//   data_sram_rvalid   one-cycle pulse marking valid read data
//   mem_to_wb_bus      {hilo 66, pc 32, rf_we, rf_waddr 5, rf_wdata 32}
//   mem_to_id_bus      {rf_we, rf_waddr 5, rf_wdata 32} forwarding to ID
//   stallreq_mem       load still waiting for its data; freeze MEM and earlier
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int FWD_WD       = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [FWD_WD-1:0]       mem_to_id_bus,
    output logic                    stallreq_mem
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HELD = 2'b10
    } state_e;

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [2:0] LT_LW  = 3'b101;

    logic [EX_TO_MEM_WD-1:0] r_q, r_d;
    state_e                  state_q, state_d;
    logic [31:0]             hold_q, hold_d;

    // Fields of the registered EX result
    logic [65:0] r_hilo;
    logic [31:0] r_pc;
    logic        r_ram_en;
    logic [3:0]  r_ram_wen;
    logic [2:0]  r_load_type;
    logic [1:0]  r_addr_lo;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        is_load;
    logic [31:0] load_src;
    logic [31:0] wdata;
    logic        unused_stall_bits;

    assign r_hilo      = r_q[EX_TO_MEM_WD-1:80];
    assign r_pc        = r_q[79:48];
    assign r_ram_en    = r_q[47];
    assign r_ram_wen   = r_q[46:43];
    assign r_load_type = r_q[42:40];
    assign r_addr_lo   = r_q[39:38];
    assign r_rf_we     = r_q[37];
    assign r_rf_waddr  = r_q[36:32];
    assign r_rf_wdata  = r_q[31:0];

    // Only the MEM and WB stall bits matter to this stage.
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    // Select and extend the addressed byte/half of a load word.
    function automatic logic [31:0] fmt_load(input logic [2:0]  lt,
                                             input logic [1:0]  a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = d[7:0];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (lt)
            LT_LB:   res = {{24{b[7]}}, b};
            LT_LBU:  res = {24'd0, b};
            LT_LH:   res = {{16{h[15]}}, h};
            LT_LHU:  res = {16'd0, h};
            LT_LW:   res = d;
            default: res = d;
        endcase
        return res;
    endfunction

    // Writes with nonzero ram_wen are stores and never wait for read data.
    assign is_load = r_ram_en
                   & (r_load_type >= LT_LB) & (r_load_type <= LT_LW)
                   & (r_ram_wen == 4'd0);

    // Input register next value: flush, then MEM bubble, then advance, else hold
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d = {EX_TO_MEM_WD{1'b0}};
        end else if (stall[3] && !stall[4]) begin
            r_d = {EX_TO_MEM_WD{1'b0}};
        end else if (!stall[3]) begin
            r_d = ex_to_mem_bus;
        end else begin
            r_d = r_q;
        end
    end

    // Data-return FSM next state and hold-buffer capture
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flush) begin
            // Any read data returning with a flush belongs to a killed load.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_load && !data_sram_rvalid) begin
                        state_d = WAIT;
                    end else if (is_load && data_sram_rvalid && stall[3]) begin
                        state_d = HELD;
                        hold_d  = data_sram_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (data_sram_rvalid) begin
                        if (!stall[3]) begin
                            state_d = IDLE;
                        end else begin
                            // Data arrived while MEM is frozen by someone else;
                            // keep it because rvalid is only a single pulse.
                            state_d = HELD;
                            hold_d  = data_sram_rdata;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                HELD: begin
                    if (!stall[3]) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= {EX_TO_MEM_WD{1'b0}};
            state_q <= IDLE;
            hold_q  <= 32'd0;
        end else begin
            r_q     <= r_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Load result and output buses
    always_comb begin
        load_src = (state_q == HELD) ? hold_q : data_sram_rdata;
        if (is_load) begin
            wdata = fmt_load(r_load_type, r_addr_lo, load_src);
        end else begin
            wdata = r_rf_wdata;
        end
        stallreq_mem  = is_load & !data_sram_rvalid
                      & ((state_q == IDLE) | (state_q == WAIT));
        mem_to_wb_bus = {r_hilo, r_pc, r_rf_we, r_rf_waddr, wdata};
        mem_to_id_bus = {r_rf_we, r_rf_waddr, wdata};
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [145:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_rvalid;
    logic [135:0] mem_to_wb_bus;
    logic [37:0]  mem_to_id_bus;
    logic         stallreq_mem;

    int checks = 0;
    int errors = 0;

    // Reference model state: the registered EX bus, and whether read data is
    // being held for a frozen load (with the held word).
    logic [145:0] m_r;
    logic         m_held;
    logic [31:0]  m_hold;
    logic         chk_on;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus),
        .stallreq_mem     (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [145:0] mk(input logic [65:0] hilo, input logic [31:0] pc,
                                        input logic en, input logic [3:0] wen,
                                        input logic [2:0] lt, input logic [1:0] a,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
        return {hilo, pc, en, wen, lt, a, we, wa, wd};
    endfunction

    function automatic logic m_is_load(input logic [145:0] r);
        int lt;
        lt = int'(r[42:40]);
        return r[47] && (lt >= 1) && (lt <= 5) && (r[46:43] == 4'd0);
    endfunction

    // Load formatting from the ISA rules, with plain arithmetic.
    function automatic logic [31:0] m_fmt(input int lt, input int a, input logic [31:0] d);
        logic [31:0] v;
        case (lt)
            1: begin
                v = (d >> (8 * a)) & 32'h0000_00FF;
                if (v >= 32'd128) v = v - 32'd256;
            end
            2: v = (d >> (8 * a)) & 32'h0000_00FF;
            3: begin
                v = (a >= 2) ? (d >> 16) : (d & 32'h0000_FFFF);
                if (v >= 32'd32768) v = v - 32'd65536;
            end
            4: v = (a >= 2) ? (d >> 16) : (d & 32'h0000_FFFF);
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for this cycle, let them settle, compare against the model.
    task automatic drive(input logic fl, input logic [5:0] st, input logic [145:0] bus,
                         input logic rv, input logic [31:0] rd);
        logic [31:0]  exp_wd;
        logic         exp_sr;
        flush            = fl;
        stall            = st;
        ex_to_mem_bus    = bus;
        data_sram_rvalid = rv;
        data_sram_rdata  = rd;
        #1;
        if (m_is_load(m_r))
            exp_wd = m_fmt(int'(m_r[42:40]), int'(m_r[39:38]), m_held ? m_hold : rd);
        else
            exp_wd = m_r[31:0];
        exp_sr = m_is_load(m_r) && !rv && !m_held;
        if (chk_on) begin
            check("model_wb", 136'(mem_to_wb_bus),
                  {m_r[145:80], m_r[79:48], m_r[37:32], exp_wd});
            check("model_id", 136'(mem_to_id_bus), 136'({m_r[37:32], exp_wd}));
            check("model_stallreq", 136'(stallreq_mem), 136'(exp_sr));
        end
    endtask

    // Advance one clock and update the model with the inputs just applied.
    task automatic tick();
        logic ld;
        @(posedge clk);
        ld = m_is_load(m_r);
        if (rst || flush) begin
            m_r    = '0;
            m_held = 1'b0;
        end else begin
            if (m_held) begin
                if (!stall[3]) m_held = 1'b0;
            end else if (ld && data_sram_rvalid && stall[3]) begin
                m_held = 1'b1;
                m_hold = data_sram_rdata;
            end
            if (stall[3] && !stall[4]) m_r = '0;
            else if (!stall[3]) m_r = ex_to_mem_bus;
        end
        @(negedge clk);
    endtask

    task automatic load_pulse(input logic [2:0] lt, input logic [1:0] a,
                              input logic [31:0] rd, input logic [31:0] exp, input string tag);
        drive(1'b0, 6'b000000, mk(66'd0, 32'hBFC0_0100, 1'b1, 4'd0, lt, a, 1'b1, 5'd9, 32'd0),
              1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b000000, 146'd0, 1'b1, rd);
        check(tag, 136'(mem_to_wb_bus[31:0]), 136'(exp));
        check({tag, "_stallreq"}, 136'(stallreq_mem), 136'd0);
        tick();
    endtask

    initial begin
        logic [145:0] alu;
        logic [145:0] lw;
        logic [145:0] rb;
        logic [5:0]   st;
        logic [65:0]  hl;
        int           sel;

        chk_on = 1'b0;
        m_r    = '0;
        m_held = 1'b0;
        m_hold = 32'd0;
        rst    = 1'b1;
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        tick();
        tick();
        rst    = 1'b0;
        chk_on = 1'b1;

        // Reset state
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        check("reset_wb", 136'(mem_to_wb_bus), 136'd0);
        check("reset_stallreq", 136'(stallreq_mem), 136'd0);
        tick();

        // ALU pass-through
        alu = mk(66'h3_1111_2222_3333_4444, 32'hBFC0_0010, 1'b0, 4'd0, 3'd0, 2'd0,
                 1'b1, 5'd5, 32'h1234_5678);
        drive(1'b0, 6'd0, alu, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'hFFFF_FFFF);
        check("alu_wb", 136'(mem_to_wb_bus),
              {66'h3_1111_2222_3333_4444, 32'hBFC0_0010, 1'b1, 5'd5, 32'h1234_5678});
        check("alu_stallreq", 136'(stallreq_mem), 136'd0);
        tick();

        // Load formatting
        load_pulse(3'b001, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, "lb_sign");
        load_pulse(3'b010, 2'd2, 32'h0080_0000, 32'h0000_0080, "lbu_zero");
        load_pulse(3'b011, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001, "lh_hi");
        load_pulse(3'b100, 2'd2, 32'h8001_7FFF, 32'h0000_8001, "lhu_hi");
        load_pulse(3'b011, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF, "lh_lo");
        load_pulse(3'b001, 2'd3, 32'h7F00_0000, 32'h0000_007F, "lb_b3");
        load_pulse(3'b101, 2'd0, 32'h8765_4321, 32'h8765_4321, "lw");
        load_pulse(3'b110, 2'd0, 32'h8765_4321, 32'h0000_0000, "lt110_none");

        // Wait states: three cycles without data, then DEADBEEF
        lw = mk(66'd0, 32'hBFC0_0200, 1'b1, 4'd0, 3'b101, 2'd0, 1'b1, 5'd7, 32'd0);
        drive(1'b0, 6'd0, lw, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'b011111, 146'd0, 1'b0, $urandom);
            check("wait_stallreq", 136'(stallreq_mem), 136'd1);
            tick();
        end
        drive(1'b0, 6'd0, 146'd0, 1'b1, 32'hDEAD_BEEF);
        check("wait_rvalid_stallreq", 136'(stallreq_mem), 136'd0);
        check("wait_wdata", 136'(mem_to_wb_bus[31:0]), 136'h0DEAD_BEEF);
        tick();
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        check("wait_after_wb", 136'(mem_to_wb_bus), 136'd0);
        tick();

        // Hold buffer: data arrives while MEM frozen by another stage
        drive(1'b0, 6'd0, lw, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b011111, 146'd0, 1'b1, 32'hCAFE_F00D);
        check("hold_first", 136'(mem_to_wb_bus[31:0]), 136'h0CAFE_F00D);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'b011111, 146'd0, 1'($urandom_range(0, 1)), $urandom | 32'h1);
            check("hold_wdata", 136'(mem_to_wb_bus[31:0]), 136'h0CAFE_F00D);
            check("hold_stallreq", 136'(stallreq_mem), 136'd0);
            tick();
        end
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'h1357_9BDF);
        check("hold_release", 136'(mem_to_wb_bus[31:0]), 136'h0CAFE_F00D);
        tick();

        // Bubble versus hold
        drive(1'b0, 6'd0, alu, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b011111, lw, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b011111, lw, 1'b0, 32'd0);
        check("hold_r", 136'(mem_to_wb_bus[31:0]), 136'h0_1234_5678);
        tick();
        drive(1'b0, 6'b001111, lw, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        check("bubble_wb", 136'(mem_to_wb_bus), 136'd0);
        tick();

        // Flush during WAIT, with a discarded rvalid
        drive(1'b0, 6'd0, lw, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b011111, 146'd0, 1'b0, 32'd0);
        check("flushwait_stallreq", 136'(stallreq_mem), 136'd1);
        tick();
        drive(1'b1, 6'b011111, lw, 1'b1, 32'h1111_1111);
        tick();
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        check("flush_wb", 136'(mem_to_wb_bus), 136'd0);
        check("flush_stallreq", 136'(stallreq_mem), 136'd0);
        tick();

        // Reset in the middle of a load
        drive(1'b0, 6'd0, lw, 1'b0, 32'd0);
        tick();
        drive(1'b0, 6'b011111, 146'd0, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        drive(1'b0, 6'b011111, lw, 1'b1, 32'h2222_2222);
        tick();
        rst = 1'b0;
        drive(1'b0, 6'd0, 146'd0, 1'b0, 32'd0);
        check("rst_wb", 136'(mem_to_wb_bus), 136'd0);
        check("rst_stallreq", 136'(stallreq_mem), 136'd0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            hl = {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
            rb = mk(hl, $urandom, 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                    3'($urandom_range(0, 7)), 2'($urandom), 1'($urandom),
                    5'($urandom), $urandom);
            sel = int'($urandom_range(0, 7));
            if (sel < 3)       st = 6'b000000;
            else if (sel < 5)  st = 6'b011111;
            else if (sel < 6)  st = 6'b001111;
            else               st = 6'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 15) == 0), st, rb, 1'($urandom), $urandom);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
